router_output_channel: RTL and testbench

ROUTER_OUTPUT_CHANNEL -- requirements
Module: router_output_channel

---
 rtl/router_output_channel.sv | 90 +++++++++
 tb/tb_router_output_channel.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_output_channel.sv
// Two-VC output channel: one flit buffer per VC, written in its own phase and sent on the link in the opposite phase.
// Optional macro OUTCH_STATS_EN adds the saturating 16-bit handshake counter port sent_cnt.
module router_output_channel #(
    parameter int FLIT_W  = 64,
    parameter int HOP_LSB = 48
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              polarity,
    input  logic              wr_en,
    input  logic              wr_vc,
    input  logic [FLIT_W-1:0] wr_data,
    output logic              empty_even,
    output logic              empty_odd,
    output logic              so_send,
    output logic [FLIT_W-1:0] so_data,
    input  logic              so_ready,
    output logic              proto_err
`ifdef OUTCH_STATS_EN
    ,
    output logic [15:0]       sent_cnt
`endif
);

    if (FLIT_W < 56 || HOP_LSB + 8 > FLIT_W) begin : g_param_check
        $error("router_output_channel: FLIT_W must be >= 56 and hold the hop field");
    end

    logic [1:0]        full;
    logic [FLIT_W-1:0] buf_even;
    logic [FLIT_W-1:0] buf_odd;
    logic              send_vc;
    logic              wr_ok;
    logic              wr_bad;
    logic              handshake;
    logic [FLIT_W-1:0] tx_flit;

    // Writes land in the VC matching the phase; the link always drains the other VC.
    assign send_vc   = ~polarity;
    assign wr_ok     = wr_en && (wr_vc == polarity) && !full[polarity];
    assign wr_bad    = wr_en && !wr_ok;
    assign so_send   = full[send_vc];
    assign handshake = so_send && so_ready;

    assign empty_even = ~full[0];
    assign empty_odd  = ~full[1];

    always_comb begin
        tx_flit = send_vc ? buf_odd : buf_even;
        so_data = tx_flit;
        so_data[HOP_LSB +: 8] = tx_flit[HOP_LSB +: 8] >> 1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full      <= 2'b00;
            buf_even  <= '0;
            buf_odd   <= '0;
            proto_err <= 1'b0;
        end else begin
            // Write and send never hit the same VC, so each bit sees at most one of set/clear.
            if (wr_ok && !polarity) begin
                buf_even <= wr_data;
                full[0]  <= 1'b1;
            end else if (handshake && !send_vc) begin
                full[0]  <= 1'b0;
            end
            if (wr_ok && polarity) begin
                buf_odd  <= wr_data;
                full[1]  <= 1'b1;
            end else if (handshake && send_vc) begin
                full[1]  <= 1'b0;
            end
            if (wr_bad) begin
                proto_err <= 1'b1;
            end
        end
    end

`ifdef OUTCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sent_cnt <= 16'h0000;
        end else if (handshake && sent_cnt != 16'hFFFF) begin
            sent_cnt <= sent_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_router_output_channel.sv
// Directed self-checking bench for router_output_channel (stats counter checked when OUTCH_STATS_EN is defined).
module tb_router_output_channel;
    localparam int FLIT_W = 64;

    logic              clk;
    logic              reset_n;
    logic              polarity;
    logic              wr_en;
    logic              wr_vc;
    logic [FLIT_W-1:0] wr_data;
    logic              empty_even;
    logic              empty_odd;
    logic              so_send;
    logic [FLIT_W-1:0] so_data;
    logic              so_ready;
    logic              proto_err;
`ifdef OUTCH_STATS_EN
    logic [15:0]       sent_cnt;
`endif

    int tests = 0;
    int fails = 0;

    router_output_channel #(.FLIT_W(FLIT_W), .HOP_LSB(48)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .polarity  (polarity),
        .wr_en     (wr_en),
        .wr_vc     (wr_vc),
        .wr_data   (wr_data),
        .empty_even(empty_even),
        .empty_odd (empty_odd),
        .so_send   (so_send),
        .so_data   (so_data),
        .so_ready  (so_ready),
        .proto_err (proto_err)
`ifdef OUTCH_STATS_EN
        ,
        .sent_cnt  (sent_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; polarity flips and the write strobe drops right after it.
    task automatic cycle();
        @(posedge clk);
        #1;
        polarity = ~polarity;
        wr_en    = 1'b0;
    endtask

    task automatic to_phase(input logic p);
        if (polarity != p) cycle();
    endtask

    task automatic apply_reset();
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (empty_even !== 1'b1) begin fails++; $display("FAIL reset_empty_even got %b want 1", empty_even); end
        tests++; if (empty_odd !== 1'b1) begin fails++; $display("FAIL reset_empty_odd got %b want 1", empty_odd); end
        tests++; if (so_send !== 1'b0) begin fails++; $display("FAIL reset_so_send got %b want 0", so_send); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
        tests++; if (so_data !== 64'h0) begin fails++; $display("FAIL reset_so_data got %h want 0", so_data); end
        #3 reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_single_flit();
        so_ready = 1'b1;
        to_phase(1'b0);
        wr_en = 1'b1; wr_vc = 1'b0; wr_data = 64'hAA0C_1122_3344_5566;
        #1;
        tests++; if (so_send !== 1'b0) begin fails++; $display("FAIL single_pre_send got %b want 0", so_send); end
        cycle();
        #1;
        tests++; if (so_send !== 1'b1) begin fails++; $display("FAIL single_send got %b want 1", so_send); end
        tests++; if (so_data !== 64'hAA06_1122_3344_5566) begin fails++; $display("FAIL single_data got %h want aa06112233445566", so_data); end
        tests++; if (empty_even !== 1'b0) begin fails++; $display("FAIL single_full got %b want 0", empty_even); end
        cycle();
        #1;
        tests++; if (empty_even !== 1'b1) begin fails++; $display("FAIL single_drained got %b want 1", empty_even); end
        tests++; if (so_send !== 1'b0) begin fails++; $display("FAIL single_idle got %b want 0", so_send); end
    endtask

    task automatic test_backpressure();
        so_ready = 1'b0;
        to_phase(1'b1);
        wr_en = 1'b1; wr_vc = 1'b1; wr_data = 64'h5581_DEAD_BEEF_0001;
        cycle();
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (so_send !== ~polarity) begin fails++; $display("FAIL bp_send[%0d] got %b want %b", i, so_send, ~polarity); end
            if (!polarity) begin
                tests++; if (so_data !== 64'h5540_DEAD_BEEF_0001) begin fails++; $display("FAIL bp_data[%0d] got %h want 5540deadbeef0001", i, so_data); end
            end
            tests++; if (empty_odd !== 1'b0) begin fails++; $display("FAIL bp_empty_odd[%0d] got %b want 0", i, empty_odd); end
            if (i < 3) cycle();
        end
        so_ready = 1'b1;
        cycle();
        #1;
        tests++; if (so_send !== 1'b1 || polarity !== 1'b0) begin fails++; $display("FAIL bp_resume got send=%b pol=%b want send=1 pol=0", so_send, polarity); end
        cycle();
        #1;
        tests++; if (empty_odd !== 1'b1) begin fails++; $display("FAIL bp_drained got %b want 1", empty_odd); end
    endtask

    task automatic test_concurrency();
        so_ready = 1'b0;
        to_phase(1'b0);
        wr_en = 1'b1; wr_vc = 1'b0; wr_data = 64'h01FF_0000_0000_00A0;
        cycle();
        wr_en = 1'b1; wr_vc = 1'b1; wr_data = 64'h0201_0000_0000_00B0;
        so_ready = 1'b1;
        #1;
        tests++; if (so_send !== 1'b1) begin fails++; $display("FAIL conc_send got %b want 1", so_send); end
        tests++; if (so_data !== 64'h017F_0000_0000_00A0) begin fails++; $display("FAIL conc_hop_ff got %h want 017f0000000000a0", so_data); end
        cycle();
        #1;
        tests++; if (empty_even !== 1'b1) begin fails++; $display("FAIL conc_empty_even got %b want 1", empty_even); end
        tests++; if (empty_odd !== 1'b0) begin fails++; $display("FAIL conc_empty_odd got %b want 0", empty_odd); end
        tests++; if (so_data !== 64'h0200_0000_0000_00B0) begin fails++; $display("FAIL conc_hop_01 got %h want 02000000000000b0", so_data); end
        cycle();
        #1;
        tests++; if (empty_odd !== 1'b1) begin fails++; $display("FAIL conc_drained got %b want 1", empty_odd); end
    endtask

    task automatic test_errors();
        so_ready = 1'b1;
        to_phase(1'b0);
        wr_en = 1'b1; wr_vc = 1'b1; wr_data = 64'hDEAD_DEAD_DEAD_DEAD;
        #1;
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL err_pre got %b want 0", proto_err); end
        cycle();
        #1;
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL err_wrong_vc got %b want 1", proto_err); end
        tests++; if (empty_odd !== 1'b1) begin fails++; $display("FAIL err_dropped got %b want 1", empty_odd); end
        cycle(); cycle();
        #1;
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", proto_err); end
        apply_reset();
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL err_cleared got %b want 0", proto_err); end
        so_ready = 1'b0;
        to_phase(1'b0);
        wr_en = 1'b1; wr_vc = 1'b0; wr_data = 64'hFF00_FFFF_FFFF_FFFF;
        cycle();
        cycle();
        wr_en = 1'b1; wr_vc = 1'b0; wr_data = 64'h1111_1111_1111_1111;
        cycle();
        #1;
        tests++; if (so_data !== 64'hFF00_FFFF_FFFF_FFFF) begin fails++; $display("FAIL err_full_kept got %h want ff00ffffffffffff", so_data); end
        tests++; if (proto_err !== 1'b1) begin fails++; $display("FAIL err_full_flag got %b want 1", proto_err); end
        so_ready = 1'b1;
        cycle();
        #1;
        tests++; if (empty_even !== 1'b1) begin fails++; $display("FAIL err_drain got %b want 1", empty_even); end
    endtask

    task automatic test_reset_mid_transfer();
        so_ready = 1'b0;
        to_phase(1'b0);
        wr_en = 1'b1; wr_vc = 1'b0; wr_data = 64'h1234_5678_9ABC_DEF0;
        cycle();
        wr_en = 1'b1; wr_vc = 1'b1; wr_data = 64'h0FED_CBA9_8765_4321;
        cycle();
        #1;
        tests++; if ({empty_even, empty_odd} !== 2'b00) begin fails++; $display("FAIL mid_both_full got %b want 00", {empty_even, empty_odd}); end
        #1 reset_n = 1'b0;
        #1;
        tests++; if ({empty_even, empty_odd} !== 2'b11) begin fails++; $display("FAIL mid_empty got %b want 11", {empty_even, empty_odd}); end
        tests++; if (so_send !== 1'b0) begin fails++; $display("FAIL mid_send got %b want 0", so_send); end
        tests++; if (so_data !== 64'h0) begin fails++; $display("FAIL mid_data got %h want 0", so_data); end
        tests++; if (proto_err !== 1'b0) begin fails++; $display("FAIL mid_err got %b want 0", proto_err); end
        #1 reset_n = 1'b1;
        so_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            #1;
            tests++; if (so_send !== 1'b0) begin fails++; $display("FAIL mid_no_send[%0d] got %b want 0", i, so_send); end
        end
    endtask

`ifdef OUTCH_STATS_EN
    task automatic test_stats();
        apply_reset();
        tests++; if (sent_cnt !== 16'h0) begin fails++; $display("FAIL stats_reset got %h want 0", sent_cnt); end
        so_ready = 1'b1;
        for (int i = 0; i < 65541; i++) begin
            wr_en = 1'b1; wr_vc = polarity; wr_data = 64'(i);
            cycle();
            if (i == 3) begin
                #1;
                tests++; if (sent_cnt !== 16'd3) begin fails++; $display("FAIL stats_count got %0d want 3", sent_cnt); end
            end
        end
        cycle(); cycle();
        #1;
        tests++; if (sent_cnt !== 16'hFFFF) begin fails++; $display("FAIL stats_saturate got %h want ffff", sent_cnt); end
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        polarity = 1'b0;
        wr_en    = 1'b0;
        wr_vc    = 1'b0;
        wr_data  = '0;
        so_ready = 1'b0;
        test_reset();
        test_single_flit();
        test_backpressure();
        test_concurrency();
        test_errors();
        test_reset_mid_transfer();
`ifdef OUTCH_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
